// File: rtl/axi_pkg.sv
// Shared AXI read-side types: burst/response encodings, read FSM states and
// default bus width constants used by the read responder and its address generator.
// Ports: none (package).
package axi_pkg;

   localparam int AXI_WIDTH   = 32;
   localparam int AXI_SIZE    = 3;
   localparam int AXI_ID_W    = AXI_WIDTH / 8;
   localparam int AXI_LEN_W   = AXI_WIDTH / 8;
   localparam int AXI_BURST_W = AXI_SIZE - 1;
   localparam int AXI_LANES   = AXI_WIDTH / 8;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_t;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_DATA = 1'b1
   } rd_state_t;

endpackage

// File: rtl/axi_rd_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts (reserved acts as INCR).
// Ports: cur_i current beat address, start_i burst start, len_i beats-1, size_i log2 bytes
//        (already clamped to the bus), burst_i burst type; next_o address of the following beat.
module axi_rd_addr_gen
   import axi_pkg::*;
#(
   parameter int WIDTH = AXI_WIDTH,
   parameter int LW    = WIDTH / 8,
   parameter int SW    = AXI_SIZE
) (
   input  logic [WIDTH-1:0] cur_i,
   input  logic [WIDTH-1:0] start_i,
   input  logic [LW-1:0]    len_i,
   input  logic [SW-1:0]    size_i,
   input  burst_t           burst_i,
   output logic [WIDTH-1:0] next_o
);

   logic [WIDTH-1:0] bytes;
   logic [WIDTH-1:0] beats;
   logic [WIDTH-1:0] region;

   always_comb begin
      bytes  = WIDTH'(1) << size_i;
      beats  = WIDTH'(len_i) + WIDTH'(1);
      region = bytes * beats;
      case (burst_i)
         BURST_FIXED: next_o = start_i;
         // Wrap inside the region-aligned window that contains the start address.
         BURST_WRAP:  next_o = (start_i & ~(region - WIDTH'(1)))
                             + ((cur_i + bytes) & (region - WIDTH'(1)));
         // INCR and reserved: align the current address to the beat size, then step,
         // so an unaligned first beat is followed by aligned beats.
         default:     next_o = (cur_i & ~(bytes - WIDTH'(1))) + bytes;
      endcase
   end

endmodule

// File: rtl/axi_rd_slave.sv
// AXI read responder: one outstanding burst, R beats returned from a local byte memory.
// Ports: clk/reset (sync, active high); AR* request channel; R* response channel;
//        mem_we/mem_waddr/mem_wdata byte preload. Optional macro AXI_RD_ERRCHK_EN enables SLVERR checks.
module axi_rd_slave
   import axi_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int SIZE      = 3,
   parameter int MEM_BYTES = 4096
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [WIDTH/8-1:0]           ARID,
   input  logic [WIDTH-1:0]             ARADDR,
   input  logic [WIDTH/8-1:0]           ARLEN,
   input  logic [SIZE-1:0]              ARSIZE,
   input  logic [SIZE-2:0]              ARBURST,
   input  logic                         ARVALID,
   output logic                         ARREADY,
   output logic [WIDTH/8-1:0]           RID,
   output logic [WIDTH-1:0]             RDATA,
   output logic [SIZE-2:0]              RRESP,
   output logic                         RLAST,
   output logic                         RVALID,
   input  logic                         RREADY,
   input  logic                         mem_we,
   input  logic [$clog2(MEM_BYTES)-1:0] mem_waddr,
   input  logic [7:0]                   mem_wdata
);

   localparam int LW  = WIDTH / 8;
   localparam int NL  = WIDTH / 8;
   localparam int LB  = $clog2(NL);
   localparam int LBW = LB + 1;
   localparam int AW  = $clog2(MEM_BYTES);

   logic [7:0] mem [MEM_BYTES];

   rd_state_t        state_q, state_d;
   logic             arready_q, arready_d;
   logic             rvalid_q, rvalid_d;
   logic             rlast_q, rlast_d;
   logic [LW-1:0]    id_q, id_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] start_q, start_d;
   logic [LW-1:0]    len_q, len_d;
   logic [SIZE-1:0]  size_q, size_d;
   burst_t           burst_q, burst_d;
   logic             szerr_q, szerr_d;
   logic [LW-1:0]    beat_q, beat_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   resp_t            rresp_q, rresp_d;

   logic [WIDTH-1:0] next_addr;

   // Attributes of the beat that would be presented after the coming edge:
   // the new request while idle, otherwise the following beat of the burst.
   logic [WIDTH-1:0] pres_addr;
   logic [SIZE-1:0]  pres_size;
   burst_t           pres_burst;
   logic [LW-1:0]    pres_len;
   logic             pres_szerr;
   logic [AW-1:0]    lane_base;
   logic [LBW-1:0]   lane_lo, lane_end, sz_bytes;
   logic [WIDTH-1:0] beat_data;
   logic             beat_err;

   axi_rd_addr_gen #(.WIDTH(WIDTH), .LW(LW), .SW(SIZE)) u_addr_gen (
      .cur_i   (addr_q),
      .start_i (start_q),
      .len_i   (len_q),
      .size_i  (size_q),
      .burst_i (burst_q),
      .next_o  (next_addr)
   );

   // Preload port; memory is deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   always_comb begin
      if (state_q == ST_IDLE) begin
         pres_addr  = ARADDR;
         pres_szerr = (ARSIZE > SIZE'(LB));
         pres_size  = pres_szerr ? SIZE'(LB) : ARSIZE;
         pres_burst = burst_t'(ARBURST);
         pres_len   = ARLEN;
      end else begin
         pres_addr  = next_addr;
         pres_szerr = szerr_q;
         pres_size  = size_q;
         pres_burst = burst_q;
         pres_len   = len_q;
      end

      // Valid lanes run from the byte offset up to the end of the size-aligned slot.
      lane_lo   = {1'b0, pres_addr[LB-1:0]};
      sz_bytes  = LBW'(1) << pres_size;
      lane_end  = (lane_lo & ~(sz_bytes - LBW'(1))) + sz_bytes;
      lane_base = {pres_addr[AW-1:LB], {LB{1'b0}}};
      beat_data = '0;
      for (int k = 0; k < NL; k++) begin
         if ((LBW'(k) >= lane_lo) && (LBW'(k) < lane_end))
            beat_data[8*k +: 8] = mem[lane_base + AW'(k)];
      end

`ifdef AXI_RD_ERRCHK_EN
      beat_err = (pres_addr >= WIDTH'(MEM_BYTES))
              || (pres_burst == BURST_RSVD)
              || pres_szerr
              || ((pres_burst == BURST_WRAP) &&
                  !((pres_len == LW'(1)) || (pres_len == LW'(3)) ||
                    (pres_len == LW'(7)) || (pres_len == LW'(15))));
`else
      beat_err = 1'b0;
`endif
   end

`ifndef AXI_RD_ERRCHK_EN
   // Only the error checks look at these; out-of-range addresses simply wrap.
   logic unused_errchk;
   assign unused_errchk = ^{pres_addr[WIDTH-1:AW], pres_burst, pres_len, pres_szerr};
`endif

   always_comb begin
      state_d   = state_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rlast_d   = rlast_q;
      id_d      = id_q;
      addr_d    = addr_q;
      start_d   = start_q;
      len_d     = len_q;
      size_d    = size_q;
      burst_d   = burst_q;
      szerr_d   = szerr_q;
      beat_d    = beat_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;

      case (state_q)
         ST_IDLE: begin
            arready_d = 1'b1;
            if (arready_q && ARVALID) begin
               state_d   = ST_DATA;
               arready_d = 1'b0;
               rvalid_d  = 1'b1;
               rlast_d   = (ARLEN == '0);
               id_d      = ARID;
               addr_d    = ARADDR;
               start_d   = ARADDR;
               len_d     = ARLEN;
               size_d    = pres_size;
               burst_d   = pres_burst;
               szerr_d   = pres_szerr;
               beat_d    = '0;
               rdata_d   = beat_err ? '0 : beat_data;
               rresp_d   = beat_err ? RESP_SLVERR : RESP_OKAY;
            end
         end
         ST_DATA: begin
            arready_d = 1'b0;
            if (rvalid_q && RREADY) begin
               if (beat_q == len_q) begin
                  state_d   = ST_IDLE;
                  rvalid_d  = 1'b0;
                  rlast_d   = 1'b0;
                  arready_d = 1'b1;
               end else begin
                  beat_d  = beat_q + LW'(1);
                  addr_d  = next_addr;
                  rlast_d = ((beat_q + LW'(1)) == len_q);
                  rdata_d = beat_err ? '0 : beat_data;
                  rresp_d = beat_err ? RESP_SLVERR : RESP_OKAY;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         id_q      <= '0;
         addr_q    <= '0;
         start_q   <= '0;
         len_q     <= '0;
         size_q    <= '0;
         burst_q   <= BURST_FIXED;
         szerr_q   <= 1'b0;
         beat_q    <= '0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         state_q   <= state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         start_q   <= start_d;
         len_q     <= len_d;
         size_q    <= size_d;
         burst_q   <= burst_d;
         szerr_q   <= szerr_d;
         beat_q    <= beat_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   assign ARREADY = arready_q;
   assign RVALID  = rvalid_q;
   assign RLAST   = rlast_q;
   assign RID     = id_q;
   assign RDATA   = rdata_q;
   assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_rd_slave.sv
// Directed bench for axi_rd_slave: preload, bursts of each type, stalls, errors, mid-burst reset.
// Ports: none (top-level bench).
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_axi_rd_slave;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  ARID;
   logic [31:0] ARADDR;
   logic [3:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic        ARVALID;
   logic        ARREADY;
   logic [3:0]  RID;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST;
   logic        RVALID;
   logic        RREADY;
   logic        mem_we;
   logic [11:0] mem_waddr;
   logic [7:0]  mem_wdata;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] exp_d [0:15];

   always #5 clk = ~clk;

   axi_rd_slave #(.WIDTH(32), .SIZE(3), .MEM_BYTES(4096)) dut (
      .clk       (clk),
      .reset     (reset),
      .ARID      (ARID),
      .ARADDR    (ARADDR),
      .ARLEN     (ARLEN),
      .ARSIZE    (ARSIZE),
      .ARBURST   (ARBURST),
      .ARVALID   (ARVALID),
      .ARREADY   (ARREADY),
      .RID       (RID),
      .RDATA     (RDATA),
      .RRESP     (RRESP),
      .RLAST     (RLAST),
      .RVALID    (RVALID),
      .RREADY    (RREADY),
      .mem_we    (mem_we),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic poke(input logic [11:0] a, input logic [7:0] d);
      mem_we    = 1'b1;
      mem_waddr = a;
      mem_wdata = d;
      @(negedge clk);
      mem_we    = 1'b0;
   endtask

   // Issue one AR request and consume the burst with the given RREADY pattern,
   // checking every sampled cycle against exp_d[beat]. Called on a falling edge.
   task automatic run_burst(input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [15:0] rr_pat,
                            input logic [1:0] exp_resp);
      int cyc;
      int beat;
      int k;
      cyc = 0;
      while (ARREADY !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("arready_idle", {31'b0, ARREADY}, 32'd1);
      ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
      ARVALID = 1'b1;
      @(negedge clk);
      ARVALID = 1'b0;
      check("rvalid_first", {31'b0, RVALID}, 32'd1);
      beat = 0;
      k    = 0;
      cyc  = 0;
      while (beat <= int'(len) && cyc < 200) begin
         RREADY = rr_pat[k % 16];
         k++;
         check("rvalid", {31'b0, RVALID}, 32'd1);
         check("rdata", RDATA, exp_d[beat]);
         check("rresp", {30'b0, RRESP}, {30'b0, exp_resp});
         check("rid", {28'b0, RID}, {28'b0, id});
         check("rlast", {31'b0, RLAST}, {31'b0, (beat == int'(len))});
         check("arready_busy", {31'b0, ARREADY}, 32'd0);
         if (RVALID && RREADY) beat++;
         @(negedge clk);
         cyc++;
      end
      RREADY = 1'b0;
      check("beats", beat, int'(len) + 1);
      check("rvalid_end", {31'b0, RVALID}, 32'd0);
      check("arready_end", {31'b0, ARREADY}, 32'd1);
   endtask

   initial begin
      reset = 1'b1; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
      ARVALID = 1'b0; RREADY = 1'b0; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_arready", {31'b0, ARREADY}, 32'd0);
      check("rst_rvalid", {31'b0, RVALID}, 32'd0);
      check("rst_rlast", {31'b0, RLAST}, 32'd0);
      check("rst_rid", {28'b0, RID}, 32'd0);
      check("rst_rdata", RDATA, 32'd0);
      check("rst_rresp", {30'b0, RRESP}, 32'd0);

      for (int i = 0; i < 16; i++) poke(12'h100 + 12'(i), 8'(i));
      for (int i = 0; i < 4; i++) poke(12'h000 + 12'(i), 8'hA0 + 8'(i));

      reset = 1'b0;
      check("arready_deassert", {31'b0, ARREADY}, 32'd0);
      @(negedge clk);
      check("arready_after_rst", {31'b0, ARREADY}, 32'd1);

      // INCR word burst
      exp_d[0] = 32'h03020100; exp_d[1] = 32'h07060504;
      exp_d[2] = 32'h0B0A0908; exp_d[3] = 32'h0F0E0D0C;
      run_burst(4'd5, 32'h100, 4'd3, 3'd2, 2'b01, 16'hFFFF, 2'b00);

      // WRAP over a 16-byte window starting mid-window
      exp_d[0] = 32'h0B0A0908; exp_d[1] = 32'h0F0E0D0C;
      exp_d[2] = 32'h03020100; exp_d[3] = 32'h07060504;
      run_burst(4'd2, 32'h108, 4'd3, 3'd2, 2'b10, 16'hFFFF, 2'b00);

      // FIXED byte burst, lane 1 only
      exp_d[0] = 32'h00000100; exp_d[1] = 32'h00000100;
      run_burst(4'd7, 32'h101, 4'd1, 3'd0, 2'b00, 16'hFFFF, 2'b00);

      // INCR with RREADY pattern 1,0,0,1,... : outputs must hold across stalls
      exp_d[0] = 32'h07060504; exp_d[1] = 32'h0B0A0908; exp_d[2] = 32'h0F0E0D0C;
      run_burst(4'd3, 32'h104, 4'd2, 3'd2, 2'b01, 16'h9249, 2'b00);

      // Unaligned halfword INCR: first beat partial, then aligned beats
      exp_d[0] = 32'h00000100; exp_d[1] = 32'h03020000; exp_d[2] = 32'h00000504;
      run_burst(4'd1, 32'h101, 4'd2, 3'd1, 2'b01, 16'hFFFF, 2'b00);

`ifdef AXI_RD_ERRCHK_EN
      exp_d[0] = 32'h00000000;
      run_burst(4'd4, 32'h1000, 4'd0, 3'd2, 2'b01, 16'hFFFF, 2'b10);
      exp_d[0] = 32'h00000000;
      run_burst(4'd6, 32'h100, 4'd0, 3'd3, 2'b01, 16'hFFFF, 2'b10);
`else
      exp_d[0] = 32'hA3A2A1A0;
      run_burst(4'd4, 32'h1000, 4'd0, 3'd2, 2'b01, 16'hFFFF, 2'b00);
      exp_d[0] = 32'h03020100;
      run_burst(4'd6, 32'h100, 4'd0, 3'd3, 2'b01, 16'hFFFF, 2'b00);
`endif

      // Reset while the second beat of a 4-beat burst is presented
      ARID = 4'd9; ARADDR = 32'h100; ARLEN = 4'd3; ARSIZE = 3'd2; ARBURST = 2'b01;
      ARVALID = 1'b1; RREADY = 1'b1;
      @(negedge clk);
      ARVALID = 1'b0;
      check("mid_beat0", RDATA, 32'h03020100);
      @(negedge clk);
      check("mid_beat1", RDATA, 32'h07060504);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_rvalid", {31'b0, RVALID}, 32'd0);
      check("mid_rst_rlast", {31'b0, RLAST}, 32'd0);
      check("mid_rst_arready", {31'b0, ARREADY}, 32'd0);
      reset = 1'b0;
      RREADY = 1'b0;
      @(negedge clk);
      check("mid_arready_back", {31'b0, ARREADY}, 32'd1);
      exp_d[0] = 32'h03020100; exp_d[1] = 32'h07060504;
      exp_d[2] = 32'h0B0A0908; exp_d[3] = 32'h0F0E0D0C;
      run_burst(4'd10, 32'h100, 4'd3, 3'd2, 2'b01, 16'hFFFF, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
